reg_bank_32: RTL and testbench



---
 rtl/reg_bank_32_pkg.sv | 20 ++
 rtl/reg_bank_32_if.sv | 28 ++
 rtl/reg_bank_32_reg_ld.sv | 23 ++
 rtl/reg_bank_32.sv | 70 +++++++
 tb/tb_reg_bank_32.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_32_pkg.sv
// Shared constants and helpers for the 32-entry architectural register bank.
package reg_bank_pkg;

  localparam int unsigned NUM_REGS      = 32;
  localparam int unsigned SEL_W         = 5;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam logic [31:0] RESET_VAL_DEF = '0;
  localparam int unsigned ZERO_REG      = 0;

  typedef logic [SEL_W-1:0] reg_sel_t;

  // One-hot decode of a register number, gated by an enable.
  function automatic logic [NUM_REGS-1:0] dec_sel(input reg_sel_t sel, input logic en);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[sel] = en;
    return v;
  endfunction

endpackage

// File: rtl/reg_bank_32_if.sv
// Write-back / reservation / read-out bundle of the register bank.
// master: issue and write-back logic; slave: the register bank itself.
interface reg_bank_32_if
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              ld;
  reg_sel_t          wsel;
  logic [DATA_W-1:0] din;
  logic              rsv;
  reg_sel_t          rsel;
  logic [DATA_W-1:0] q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [15:0]       wr_count;

  modport master (
    output ld, wsel, din, rsv, rsel,
    input  q, busy, wr_count
  );

  modport slave (
    input  ld, wsel, din, rsv, rsel,
    output q, busy, wr_count
  );

endinterface

// File: rtl/reg_bank_32_reg_ld.sv
// DATA_W-bit register with load enable and asynchronous active-high reset.
module reg_ld #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ld,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Hold the value until a load; reset restores RESET_VAL immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_q <= RESET_VAL;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank_32.sv
// Architectural register bank: 32 x DATA_W registers, write-port decoder,
// per-register busy scoreboard and saturating write counter.
// Optional macro REG_BANK_ZERO_REG_EN hardwires register 0 to zero and
// ignores writes/reservations that target it.
module reg_bank_32
  import reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
  input logic          clk,
  input logic          reset,
  reg_bank_32_if.slave bus
);

`ifdef REG_BANK_ZERO_REG_EN
  localparam int unsigned         FIRST_REG = ZERO_REG + 1;
  localparam logic [NUM_REGS-1:0] SEL_MASK  = ~(NUM_REGS'(1) << ZERO_REG);
`else
  localparam int unsigned         FIRST_REG = 0;
  localparam logic [NUM_REGS-1:0] SEL_MASK  = '1;
`endif

  logic [NUM_REGS-1:0] w_ld_en;
  logic [NUM_REGS-1:0] w_rsv_set;
  logic                w_wr_acc;
  logic [NUM_REGS-1:0] r_busy;
  logic [15:0]         r_wr_count;

  // Decode write and reservation targets into per-register strobes.
  always_comb begin
    w_ld_en   = dec_sel(bus.wsel, bus.ld)  & SEL_MASK;
    w_rsv_set = dec_sel(bus.rsel, bus.rsv) & SEL_MASK;
    w_wr_acc  = |w_ld_en;
  end

`ifdef REG_BANK_ZERO_REG_EN
  assign bus.q[ZERO_REG] = '0;
`endif

  for (genvar g = FIRST_REG; g < NUM_REGS; g++) begin : g_reg
    reg_ld #(
      .DATA_W   (DATA_W),
      .RESET_VAL(RESET_VAL)
    ) u_reg (
      .clk  (clk),
      .reset(reset),
      .i_ld (w_ld_en[g]),
      .i_d  (bus.din),
      .o_q  (bus.q[g])
    );
  end

  // Scoreboard: a write clears its target, a reservation sets it; the
  // set is applied last so a same-edge new producer wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_ld_en) | w_rsv_set;
  end

  // Count accepted writes, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_wr_count <= '0;
    else if (w_wr_acc && r_wr_count != '1) r_wr_count <= r_wr_count + 16'd1;
  end

  assign bus.busy     = r_busy;
  assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_bank_32.sv
// Self-checking bench for reg_bank_32 against an array-based reference model.
module tb_reg_bank_32;
  import reg_bank_pkg::*;

`ifdef REG_BANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk;
  logic reset;

  reg_bank_32_if #(.DATA_W(32)) bus ();

  reg_bank_32 #(
    .DATA_W   (32),
    .RESET_VAL(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;

  // Reference model state
  logic [31:0] m_q [32];
  bit          m_busy [32];
  int unsigned m_cnt;

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_q[i]    = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Drive one cycle of stimulus at the falling edge, apply the
  // architectural rules at the rising edge, return 1 ns later.
  task automatic do_cycle(input bit ld, input int wsel, input logic [31:0] din,
                          input bit rsv, input int rsel);
    @(negedge clk);
    bus.ld   = ld;
    bus.wsel = 5'(wsel);
    bus.din  = din;
    bus.rsv  = rsv;
    bus.rsel = 5'(rsel);
    @(posedge clk);
    if (ld && !(ZR && wsel == 0)) begin
      m_q[wsel]    = din;
      m_busy[wsel] = 1'b0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    if (rsv && !(ZR && rsel == 0)) m_busy[rsel] = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld   = 1'b0;
    bus.wsel = '0;
    bus.din  = '0;
    bus.rsv  = 1'b0;
    bus.rsel = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, i + 1, $urandom, 1'b1, i + 10);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.q[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_async_q%0d: got %h expected %h", i, bus.q[i], 32'h0);
      end
    end
    checks++;
    if (bus.busy !== 32'h0) begin
      errors++;
      $display("FAIL reset_async_busy: got %h expected %h", bus.busy, 32'h0);
    end
    checks++;
    if (bus.wr_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_async_count: got %h expected %h", bus.wr_count, 16'h0);
    end
    // Held while reset stays high, even with a write presented.
    @(negedge clk);
    bus.ld = 1'b1; bus.wsel = 5'd3; bus.din = 32'hCAFE0003;
    bus.rsv = 1'b1; bus.rsel = 5'd3;
    @(posedge clk);
    #1;
    checks++;
    if (bus.q[3] !== 32'h0 || bus.busy !== 32'h0 || bus.wr_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold: got q3=%h busy=%h cnt=%h expected all zero",
               bus.q[3], bus.busy, bus.wr_count);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_write_sweep();
    pulse_reset();
    for (int n = 0; n < 32; n++) begin
      do_cycle(1'b1, n, 32'hA5A50000 + n, 1'b0, 0);
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (bus.q[i] !== m_q[i]) begin
          errors++;
          $display("FAIL sweep_w%0d_q%0d: got %h expected %h", n, i, bus.q[i], m_q[i]);
        end
      end
    end
    for (int n = 1; n < 32; n++) begin
      checks++;
      if (bus.q[n] !== 32'hA5A50000 + n) begin
        errors++;
        $display("FAIL sweep_final_q%0d: got %h expected %h", n, bus.q[n], 32'hA5A50000 + n);
      end
    end
    checks++;
    if (bus.q[0] !== (ZR ? 32'h0 : 32'hA5A50000)) begin
      errors++;
      $display("FAIL sweep_final_q0: got %h expected %h", bus.q[0], ZR ? 32'h0 : 32'hA5A50000);
    end
    checks++;
    if (bus.wr_count !== (ZR ? 16'd31 : 16'd32)) begin
      errors++;
      $display("FAIL sweep_count: got %0d expected %0d", bus.wr_count, ZR ? 31 : 32);
    end
  endtask

  task automatic test_ld_off();
    logic [15:0] cnt_before;
    cnt_before = bus.wr_count;
    do_cycle(1'b0, 7, 32'hDEADBEEF, 1'b0, 0);
    checks++;
    if (bus.q[7] !== 32'hA5A50007) begin
      errors++;
      $display("FAIL ld_off_q7: got %h expected %h", bus.q[7], 32'hA5A50007);
    end
    checks++;
    if (bus.wr_count !== cnt_before) begin
      errors++;
      $display("FAIL ld_off_count: got %0d expected %0d", bus.wr_count, cnt_before);
    end
  endtask

  task automatic test_scoreboard();
    do_cycle(1'b0, 0, 32'h0, 1'b1, 5);
    checks++;
    if (bus.busy !== 32'h00000020) begin
      errors++;
      $display("FAIL sb_set: got %h expected %h", bus.busy, 32'h00000020);
    end
    do_cycle(1'b0, 0, 32'h0, 1'b1, 5);
    checks++;
    if (bus.busy !== 32'h00000020) begin
      errors++;
      $display("FAIL sb_reset_again: got %h expected %h", bus.busy, 32'h00000020);
    end
    do_cycle(1'b1, 5, 32'h55AA0005, 1'b0, 0);
    checks++;
    if (bus.busy !== 32'h0) begin
      errors++;
      $display("FAIL sb_clear: got %h expected %h", bus.busy, 32'h0);
    end
    checks++;
    if (bus.q[5] !== 32'h55AA0005) begin
      errors++;
      $display("FAIL sb_q5: got %h expected %h", bus.q[5], 32'h55AA0005);
    end
    // Write to a non-busy register leaves busy clear; independent set elsewhere.
    do_cycle(1'b1, 12, 32'h0000000C, 1'b1, 20);
    checks++;
    if (bus.busy !== 32'h00100000 || bus.q[12] !== 32'h0000000C) begin
      errors++;
      $display("FAIL sb_indep: got busy=%h q12=%h expected busy=%h q12=%h",
               bus.busy, bus.q[12], 32'h00100000, 32'h0000000C);
    end
  endtask

  task automatic test_collision();
    do_cycle(1'b1, 9, 32'h00001234, 1'b1, 9);
    checks++;
    if (bus.q[9] !== 32'h00001234) begin
      errors++;
      $display("FAIL coll_q9: got %h expected %h", bus.q[9], 32'h00001234);
    end
    checks++;
    if (bus.busy[9] !== 1'b1) begin
      errors++;
      $display("FAIL coll_busy9: got %b expected 1", bus.busy[9]);
    end
  endtask

  task automatic test_zero_reg();
    do_cycle(1'b1, 0, 32'hFFFF0000, 1'b1, 0);
    checks++;
    if (bus.q[0] !== m_q[0] || bus.busy !== m_busy_vec() || bus.wr_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL zero_reg: got q0=%h busy=%h cnt=%0d expected q0=%h busy=%h cnt=%0d",
               bus.q[0], bus.busy, bus.wr_count, m_q[0], m_busy_vec(), m_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      do_cycle(1'($urandom), int'($urandom_range(31)), $urandom,
               1'($urandom), int'($urandom_range(31)));
      checks++;
      if (bus.busy !== m_busy_vec()) begin
        errors++;
        $display("FAIL rand_busy c%0d: got %h expected %h", c, bus.busy, m_busy_vec());
      end
      checks++;
      if (bus.wr_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_count c%0d: got %0d expected %0d", c, bus.wr_count, m_cnt);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (bus.q[i] !== m_q[i]) begin
          errors++;
          $display("FAIL rand_q%0d c%0d: got %h expected %h", i, c, bus.q[i], m_q[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int c = 1; c <= 65540; c++) begin
      do_cycle(1'b1, int'($urandom_range(31, 1)), $urandom, 1'b0, 0);
      if (c == 65534 || c == 65535 || c == 65540) begin
        checks++;
        if (bus.wr_count !== 16'(m_cnt)) begin
          errors++;
          $display("FAIL sat_count w%0d: got %h expected %h", c, bus.wr_count, 16'(m_cnt));
        end
      end
    end
    checks++;
    if (bus.wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final: got %h expected %h", bus.wr_count, 16'hFFFF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_write_sweep();
    test_ld_off();
    test_scoreboard();
    test_collision();
    test_zero_reg();
    test_random();
    test_saturation();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
